// File: rtl/exe_forward_hazard_ctrl.sv
// Purpose: EXE-stage sequencing control: shadow EXE/MEM destination slots, operand forward selects, ID hazard stall, branch flush, stall counter.
// Latency: hazard/flush combinational (0 cycles); sel_src1/sel_src2 registered, valid the cycle after issue.
// Backpressure: mem_freeze holds every register; hazard stalls IF/ID and injects a bubble into EXE.
module exe_forward_hazard_ctrl #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              forward_en,
    input  logic              mem_freeze,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_use_src2,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              exe_branch_taken,
    output logic              hazard,
    output logic              flush,
    output logic [1:0]        sel_src1,
    output logic [1:0]        sel_src2,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

    // Shadow slots. The WB slot is not kept: once an instruction leaves MEM
    // the register file write precedes the read, so nothing past MEM can
    // hazard, and a WB forward is chosen at issue from the MEM slot.
    logic              exe_vld_q,  exe_vld_d;
    logic [REG_AW-1:0] exe_dest_q, exe_dest_d;
    logic              exe_wb_q,   exe_wb_d;
    logic              exe_mrd_q,  exe_mrd_d;
    logic              mem_vld_q,  mem_vld_d;
    logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
    logic              mem_wb_q,   mem_wb_d;
    logic [1:0]        sel1_q,     sel1_d;
    logic [1:0]        sel2_q,     sel2_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic m1_exe, m2_exe, m1_mem, m2_mem;
    logic hazard_raw, issue;

    // Source/destination matches against the EXE and MEM slots.
    always_comb begin
        m1_exe = id_use_src1 & exe_vld_q & exe_wb_q & (exe_dest_q == id_src1);
        m2_exe = id_use_src2 & exe_vld_q & exe_wb_q & (exe_dest_q == id_src2);
        m1_mem = id_use_src1 & mem_vld_q & mem_wb_q & (mem_dest_q == id_src1);
        m2_mem = id_use_src2 & mem_vld_q & mem_wb_q & (mem_dest_q == id_src2);
    end

    // Hazard/flush decision; a taken branch squashes ID so it outranks any stall.
    always_comb begin
        flush = exe_branch_taken & ~mem_freeze;
        if (forward_en) begin
            hazard_raw = id_valid & exe_mrd_q & (m1_exe | m2_exe);
        end else begin
            hazard_raw = id_valid & (m1_exe | m2_exe | m1_mem | m2_mem);
        end
        hazard = hazard_raw & ~flush;
        issue  = id_valid & ~hazard & ~flush;
    end

    // Next-state: advance slots, pick operand selects at issue, count stalls.
    always_comb begin
        exe_vld_d   = exe_vld_q;
        exe_dest_d  = exe_dest_q;
        exe_wb_d    = exe_wb_q;
        exe_mrd_d   = exe_mrd_q;
        mem_vld_d   = mem_vld_q;
        mem_dest_d  = mem_dest_q;
        mem_wb_d    = mem_wb_q;
        sel1_d      = sel1_q;
        sel2_d      = sel2_q;
        stall_cnt_d = stall_cnt_q;
        if (!mem_freeze) begin
            mem_vld_d  = exe_vld_q;
            mem_dest_d = exe_dest_q;
            mem_wb_d   = exe_wb_q;
            exe_vld_d  = issue;
            exe_dest_d = issue ? id_dest     : '0;
            exe_wb_d   = issue & id_wb_en;
            exe_mrd_d  = issue & id_mem_read;
            sel1_d     = SEL_RF;
            sel2_d     = SEL_RF;
            if (issue && forward_en) begin
                // The EXE-slot producer is the younger writer, so it wins.
                sel1_d = m1_exe ? SEL_MEM : (m1_mem ? SEL_WB : SEL_RF);
                sel2_d = m2_exe ? SEL_MEM : (m2_mem ? SEL_WB : SEL_RF);
            end
            if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers, cleared asynchronously so in-flight slots are dropped on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_vld_q   <= 1'b0;
            exe_dest_q  <= '0;
            exe_wb_q    <= 1'b0;
            exe_mrd_q   <= 1'b0;
            mem_vld_q   <= 1'b0;
            mem_dest_q  <= '0;
            mem_wb_q    <= 1'b0;
            sel1_q      <= SEL_RF;
            sel2_q      <= SEL_RF;
            stall_cnt_q <= '0;
        end else begin
            exe_vld_q   <= exe_vld_d;
            exe_dest_q  <= exe_dest_d;
            exe_wb_q    <= exe_wb_d;
            exe_mrd_q   <= exe_mrd_d;
            mem_vld_q   <= mem_vld_d;
            mem_dest_q  <= mem_dest_d;
            mem_wb_q    <= mem_wb_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sel_src1    = sel1_q;
    assign sel_src2    = sel2_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_exe_forward_hazard_ctrl.sv
// Purpose: directed self-checking bench for exe_forward_hazard_ctrl (16-bit and 4-bit counter instances).
// Latency: comb outputs sampled 1ns after inputs change; registered outputs 1ns after posedge.
// Backpressure: mem_freeze and branch flush exercised directly from the stimulus sequence.
module tb_exe_forward_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       forward_en;
    logic       mem_freeze;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_use_src1;
    logic       id_use_src2;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_mem_read;
    logic       exe_branch_taken;

    logic        hazard, flush;
    logic [1:0]  sel_src1, sel_src2;
    logic [15:0] stall_count;

    logic        s_hazard, s_flush;
    logic [1:0]  s_sel_src1, s_sel_src2;
    logic [3:0]  s_stall_count;

    int vectors;
    int miscompares;

    exe_forward_hazard_ctrl #(.REG_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .mem_freeze(mem_freeze),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
        .hazard(hazard), .flush(flush), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .stall_count(stall_count)
    );

    exe_forward_hazard_ctrl #(.REG_AW(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .forward_en(forward_en), .mem_freeze(mem_freeze),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .exe_branch_taken(exe_branch_taken),
        .hazard(s_hazard), .flush(s_flush), .sel_src1(s_sel_src1), .sel_src2(s_sel_src2),
        .stall_count(s_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // valid, src1, use1, src2, use2, dest, wb_en, mem_read
    task automatic set_id(input logic v, input logic [3:0] s1, input logic u1,
                          input logic [3:0] s2, input logic u2, input logic [3:0] d,
                          input logic wb, input logic mr);
        id_valid = v; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
        id_dest = d; id_wb_en = wb; id_mem_read = mr;
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        forward_en = 1'b1;
        mem_freeze = 1'b0;
        exe_branch_taken = 1'b0;
        set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Reset state
        chk("rst_sel1", sel_src1, 2'd0);
        chk("rst_sel2", sel_src2, 2'd0);
        chk("rst_cnt", stall_count, 16'd0);
        chk("rst_hazard", hazard, 1'b0);
        #8 rst = 1'b1;
        tick();

        // 1: MEM forward, ADD R1 then ADD R2,R1,R3
        set_id(1, 4'd2, 1, 4'd3, 1, 4'd1, 1, 0);
        tick();
        set_id(1, 4'd1, 1, 4'd3, 1, 4'd2, 1, 0);
        chk("t1_hazard", hazard, 1'b0);
        tick();
        chk("t1_sel1", sel_src1, 2'd1);
        chk("t1_sel2", sel_src2, 2'd0);
        idle(3);
        chk("t1_idle_sel1", sel_src1, 2'd0);

        // 2: WB forward, writer R1, unrelated, reader R1
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 0);
        tick();
        set_id(1, 4'd7, 1, 4'd8, 1, 4'd6, 1, 0);
        tick();
        set_id(1, 4'd1, 1, 4'd9, 1, 4'd10, 1, 0);
        chk("t2_hazard", hazard, 1'b0);
        tick();
        chk("t2_sel1", sel_src1, 2'd2);
        chk("t2_sel2", sel_src2, 2'd0);
        idle(3);

        // 3: load-use, LDR R4 then ADD with R4 as src2
        set_id(1, 4'd5, 1, 4'd0, 0, 4'd4, 1, 1);
        tick();
        set_id(1, 4'd6, 1, 4'd4, 1, 4'd7, 1, 0);
        chk("t3_hazard", hazard, 1'b1);
        chk("t3_flush", flush, 1'b0);
        tick();
        chk("t3_cnt", stall_count, 16'd1);
        chk("t3_bubble_sel2", sel_src2, 2'd0);
        chk("t3_hazard_clear", hazard, 1'b0);
        tick();
        chk("t3_sel2", sel_src2, 2'd2);
        chk("t3_sel1", sel_src1, 2'd0);
        chk("t3_cnt_hold", stall_count, 16'd1);
        idle(3);

        // 4: stall-only mode, writer R5 then reader R5 (count is cumulative: 1 + 2)
        forward_en = 1'b0;
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 0);
        tick();
        set_id(1, 4'd5, 1, 4'd0, 0, 4'd11, 1, 0);
        chk("t4_hazard_exe", hazard, 1'b1);
        tick();
        chk("t4_hazard_mem", hazard, 1'b1);
        tick();
        chk("t4_hazard_wb", hazard, 1'b0);
        tick();
        chk("t4_sel1", sel_src1, 2'd0);
        chk("t4_cnt", stall_count, 16'd3);
        idle(3);
        forward_en = 1'b1;

        // 5: flush with RAW pending, then flush under freeze
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 1);
        tick();
        set_id(1, 4'd4, 1, 4'd0, 0, 4'd12, 1, 0);
        exe_branch_taken = 1'b1;
        #1;
        chk("t5_flush", flush, 1'b1);
        chk("t5_hazard", hazard, 1'b0);
        tick();
        exe_branch_taken = 1'b0;
        chk("t5_bubble_sel1", sel_src1, 2'd0);
        chk("t5_cnt", stall_count, 16'd3);
        // MEM holds LDR R4; issue a load of R8 that reads R4 (WB forward)
        set_id(1, 4'd0, 0, 4'd4, 1, 4'd8, 1, 1);
        chk("t5_nohazard", hazard, 1'b0);
        tick();
        chk("t5_sel2", sel_src2, 2'd2);
        // Freeze plus branch with load-use against R8 pending
        mem_freeze = 1'b1;
        exe_branch_taken = 1'b1;
        set_id(1, 4'd8, 1, 4'd0, 0, 4'd13, 1, 0);
        chk("t5_frz_flush", flush, 1'b0);
        chk("t5_frz_hazard", hazard, 1'b1);
        tick();
        chk("t5_frz_sel2", sel_src2, 2'd2);
        chk("t5_frz_cnt", stall_count, 16'd3);
        mem_freeze = 1'b0;
        exe_branch_taken = 1'b0;
        #1;
        chk("t5_held_exe_hazard", hazard, 1'b1);
        tick();
        chk("t5_unfrz_cnt", stall_count, 16'd4);
        tick();
        chk("t5_fwd_sel1", sel_src1, 2'd2);
        idle(3);

        // 6: async reset mid-stream with hazard active
        set_id(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0);
        tick();
        set_id(1, 4'd2, 1, 4'd0, 0, 4'd3, 1, 1);
        tick();
        chk("t6_pre_sel1", sel_src1, 2'd1);
        set_id(1, 4'd3, 1, 4'd0, 0, 4'd14, 1, 0);
        chk("t6_pre_hazard", hazard, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_hazard", hazard, 1'b0);
        chk("t6_rst_sel1", sel_src1, 2'd0);
        chk("t6_rst_cnt", stall_count, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_post_hazard", hazard, 1'b0);
        tick();
        idle(3);

        // Saturation: 10 writer/reader pairs in stall-only mode give 20 stalls
        forward_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_id(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0);
            tick();
            set_id(1, 4'd3, 1, 4'd0, 0, 4'd0, 0, 0);
            tick();
            tick();
            tick();
        end
        chk("sat_cnt16", stall_count, 16'd20);
        chk("sat_cnt4", s_stall_count, 4'd15);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
